// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared cache interface types: arbiter FSM state and client id
package cache_interface_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        ARB_CLIENT_I,
        ARB_CLIENT_D
    } arb_client_t;

endpackage

// File: rtl/memory_interface.sv
// rtl/memory_interface.sv - line-wide memory request/response port shared by caches and memory
interface memory_interface #(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 256
);
    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] wr_data;
    logic [LINE_SIZE-1:0] rd_data;
    logic                 write;
    logic                 valid;
    logic                 ready;

    modport master (
        output addr, wr_data, write, valid,
        input  rd_data, ready
    );

    modport slave (
        input  addr, wr_data, write, valid,
        output rd_data, ready
    );
endinterface

// File: rtl/memory_arbiter_pick2.sv
// rtl/memory_arbiter_pick2.sv - two-way client picker; round-robin under ARB_ROUND_ROBIN_EN, else D-cache priority
module arb_pick2
    import cache_interface_types::*;
(
    input  logic [1:0]  req_i,
    output arb_client_t grant_o
`ifdef ARB_ROUND_ROBIN_EN
    ,
    input  arb_client_t last_i
`endif
);

    always_comb begin
        grant_o = ARB_CLIENT_I;
        if (req_i == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_o = (last_i == ARB_CLIENT_D) ? ARB_CLIENT_I : ARB_CLIENT_D;
`else
            grant_o = ARB_CLIENT_D;
`endif
        end else if (req_i[1]) begin
            grant_o = ARB_CLIENT_D;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one memory port between I-cache and D-cache; ARB_ROUND_ROBIN_EN selects round-robin
module memory_arbiter
    import cache_interface_types::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 256
) (
    input logic             clk_i,
    input logic             reset_ni,
    memory_interface.slave  icache_bus,
    memory_interface.slave  dcache_bus,
    memory_interface.master memory_bus
);

    arb_state_t           state_q, state_d;
    arb_client_t          owner_q, owner_d;
    logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
    logic [LINE_SIZE-1:0] req_wdata_q, req_wdata_d;
    logic                 req_write_q, req_write_d;
    logic [LINE_SIZE-1:0] rsp_data_q, rsp_data_d;
    arb_client_t          grant;
`ifdef ARB_ROUND_ROBIN_EN
    arb_client_t          rr_last_q, rr_last_d;
`endif

    arb_pick2 u_pick (
        .req_i   ({dcache_bus.valid, icache_bus.valid}),
        .grant_o (grant)
`ifdef ARB_ROUND_ROBIN_EN
        ,
        .last_i  (rr_last_q)
`endif
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ARB_IDLE;
            owner_q     <= ARB_CLIENT_I;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= ARB_CLIENT_D;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_write_q <= req_write_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_write_d = req_write_q;
        rsp_data_d  = rsp_data_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                // Valid is only sampled here; later arrivals wait with ready held high.
                if (memory_bus.ready && (icache_bus.valid || dcache_bus.valid)) begin
                    owner_d = grant;
                    state_d = ARB_ISSUE;
                    if (grant == ARB_CLIENT_D) begin
                        req_addr_d  = dcache_bus.addr;
                        req_wdata_d = dcache_bus.wr_data;
                        req_write_d = dcache_bus.write;
                    end else begin
                        req_addr_d  = icache_bus.addr;
                        req_wdata_d = icache_bus.wr_data;
                        req_write_d = icache_bus.write;
                    end
                end
            end
            ARB_ISSUE: begin
                if (!memory_bus.ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (memory_bus.ready) begin
                    rsp_data_d = memory_bus.rd_data;
                    state_d    = ARB_RESP;
                end
            end
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
                rr_last_d = owner_q;
`endif
                state_d   = ARB_IDLE;
            end
        endcase
    end

    // Idle readiness follows memory so an idle cache sees exactly the memory handshake.
    always_comb begin
        memory_bus.valid   = (state_q == ARB_ISSUE);
        memory_bus.addr    = '0;
        memory_bus.wr_data = '0;
        memory_bus.write   = 1'b0;
        icache_bus.rd_data = rsp_data_q;
        dcache_bus.rd_data = rsp_data_q;
        icache_bus.ready   = memory_bus.ready;
        dcache_bus.ready   = memory_bus.ready;
        case (state_q)
            ARB_ISSUE, ARB_WAIT: begin
                memory_bus.addr    = req_addr_q;
                memory_bus.wr_data = req_wdata_q;
                memory_bus.write   = req_write_q;
                icache_bus.ready   = (owner_q != ARB_CLIENT_I);
                dcache_bus.ready   = (owner_q != ARB_CLIENT_D);
            end
            ARB_RESP: begin
                icache_bus.ready = 1'b1;
                dcache_bus.ready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter with a scoreboarded memory model
module tb_memory_arbiter;
    import cache_interface_types::*;

    localparam int AW = 32;
    localparam int LW = 256;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic          write;
        logic [LW-1:0] rdata;
        int            lat;
        int            stall;
    } sb_t;

    typedef struct {
        int            c;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic          write;
        int            lat;
        int            stall;
        logic [LW-1:0] rdata;
        bit            drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) icache_if ();
    memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) dcache_if ();
    memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) mem_if ();

    memory_arbiter #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) dut (
        .clk_i      (clk),
        .reset_ni   (rst_n),
        .icache_bus (icache_if),
        .dcache_bus (dcache_if),
        .memory_bus (mem_if)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  mem_rise_cyc = 0;
    bit  mem_auto = 1'b1;
    sb_t sb_q[$];
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic rdy(input int c);
        return (c == 0) ? icache_if.ready : dcache_if.ready;
    endfunction

    function automatic logic vld(input int c);
        return (c == 0) ? icache_if.valid : dcache_if.valid;
    endfunction

    function automatic logic [LW-1:0] rdd(input int c);
        return (c == 0) ? icache_if.rd_data : dcache_if.rd_data;
    endfunction

    task automatic set_req(input int c, input logic [AW-1:0] a, input logic [LW-1:0] d, input logic w);
        if (c == 0) begin
            icache_if.addr = a; icache_if.wr_data = d; icache_if.write = w; icache_if.valid = 1'b1;
        end else begin
            dcache_if.addr = a; dcache_if.wr_data = d; dcache_if.write = w; dcache_if.valid = 1'b1;
        end
    endtask

    task automatic drop_valid(input int c);
        if (c == 0) icache_if.valid = 1'b0;
        else        dcache_if.valid = 1'b0;
    endtask

    // Behaves like an unmodified cache FSM: raise valid, wait ready fall then rise, read line.
    task automatic client_req(input int c, input logic [AW-1:0] a, input logic [LW-1:0] d, input logic w,
                              input logic [LW-1:0] exp_rd, input bit drop_early, input bit immediate,
                              input string tag);
        int t;
        bit other_ok;
        other_ok = 1'b1;
        set_req(c, a, d, w);
        t = 0;
        while (rdy(c) !== 1'b0 && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 300) begin
            check({tag, "_grant_timeout"}, LW'(t), LW'(0));
            drop_valid(c);
            return;
        end
        if (immediate) check({tag, "_grant_latency"}, LW'(t), LW'(1));
        if (drop_early) drop_valid(c);
        t = 0;
        while (rdy(c) !== 1'b1 && t < 300) begin
            if (vld(1 - c) !== 1'b1 && rdy(1 - c) !== 1'b1) other_ok = 1'b0;
            @(posedge clk); #1; t++;
        end
        if (t >= 300) begin
            check({tag, "_done_timeout"}, LW'(t), LW'(0));
            drop_valid(c);
            return;
        end
        check({tag, "_rise_latency"}, LW'(cyc - mem_rise_cyc), LW'(1));
        check({tag, "_rd_data"}, rdd(c), exp_rd);
        check({tag, "_other_ready"}, LW'(other_ok), LW'(1));
        drop_valid(c);
        @(posedge clk); #1;
        check({tag, "_rd_hold"}, rdd(c), exp_rd);
    endtask

    task automatic collide(input logic [AW-1:0] ia, input logic [AW-1:0] da, input bit d_first, input string tag);
        sb_t ie, de;
        ie = '{addr: ia, wdata: '0, write: 1'b0, rdata: {8{ia}}, lat: 2, stall: 0};
        de = '{addr: da, wdata: '0, write: 1'b0, rdata: {8{da}}, lat: 2, stall: 0};
        if (d_first) begin sb_q.push_back(de); sb_q.push_back(ie); end
        else         begin sb_q.push_back(ie); sb_q.push_back(de); end
        fork
            client_req(0, ia, '0, 1'b0, {8{ia}}, 1'b0, 1'b0, {tag, "_i"});
            client_req(1, da, '0, 1'b0, {8{da}}, 1'b0, 1'b0, {tag, "_d"});
        join
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Memory model: pops the expected request, checks it, then runs the ready-drop/ready-rise handshake.
    initial begin
        sb_t e;
        bit  ok;
        mem_if.ready   = 1'b1;
        mem_if.rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_auto && rst_n && mem_if.valid === 1'b1 && mem_if.ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mem_unexpected: got request addr %h expected none", mem_if.addr);
                    e = '{addr: mem_if.addr, wdata: '0, write: 1'b0, rdata: '0, lat: 1, stall: 0};
                end else begin
                    e = sb_q.pop_front();
                    check("mem_addr", LW'(mem_if.addr), LW'(e.addr));
                    check("mem_wdata", mem_if.wr_data, e.wdata);
                    check("mem_write", LW'(mem_if.write), LW'(e.write));
                end
                ok = 1'b1;
                repeat (e.stall) begin
                    @(posedge clk); #1;
                    if (mem_if.valid !== 1'b1) ok = 1'b0;
                end
                if (e.stall > 0) check("issue_hold_valid", LW'(ok), LW'(1));
                mem_if.ready = 1'b0;
                ok = 1'b1;
                repeat (e.lat) begin
                    @(posedge clk); #1;
                    if (mem_if.addr !== e.addr || mem_if.write !== e.write || mem_if.valid !== 1'b0) ok = 1'b0;
                end
                check("wait_req_held", LW'(ok), LW'(1));
                mem_if.rd_data = e.rdata;
                mem_if.ready   = 1'b1;
                mem_rise_cyc   = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

    initial begin
        bit d_first;
        icache_if.valid = 1'b0; icache_if.addr = '0; icache_if.wr_data = '0; icache_if.write = 1'b0;
        dcache_if.valid = 1'b0; dcache_if.addr = '0; dcache_if.wr_data = '0; dcache_if.write = 1'b0;

        vecs[0] = '{c: 0, addr: 32'h100,  wdata: '0,              write: 1'b0, lat: 3, stall: 0, rdata: {32{8'hAA}},         drop: 1'b0};
        vecs[1] = '{c: 1, addr: 32'h2000, wdata: {32{8'h55}},     write: 1'b1, lat: 2, stall: 0, rdata: {32{8'h11}},         drop: 1'b0};
        vecs[2] = '{c: 0, addr: 32'h140,  wdata: '0,              write: 1'b0, lat: 1, stall: 0, rdata: {8{32'hDEADBEEF}},   drop: 1'b0};
        vecs[3] = '{c: 1, addr: 32'h2040, wdata: '0,              write: 1'b0, lat: 4, stall: 3, rdata: {16{16'h1234}},      drop: 1'b0};
        vecs[4] = '{c: 0, addr: 32'h180,  wdata: {8{32'hCAFEF00D}}, write: 1'b1, lat: 2, stall: 0, rdata: {32{8'h3C}},       drop: 1'b1};
        vecs[5] = '{c: 1, addr: 32'h20C0, wdata: '0,              write: 1'b0, lat: 1, stall: 1, rdata: {32{8'hC3}},         drop: 1'b1};

        #2;
        check("rst_mem_valid", LW'(mem_if.valid), LW'(0));
        check("rst_mem_addr", LW'(mem_if.addr), LW'(0));
        check("rst_i_ready", LW'(icache_if.ready), LW'(1));
        check("rst_d_ready", LW'(dcache_if.ready), LW'(1));
        check("rst_rd_data", icache_if.rd_data, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{addr: vecs[i].addr, wdata: vecs[i].wdata, write: vecs[i].write,
                             rdata: vecs[i].rdata, lat: vecs[i].lat, stall: vecs[i].stall});
            client_req(vecs[i].c, vecs[i].addr, vecs[i].wdata, vecs[i].write, vecs[i].rdata,
                       vecs[i].drop, 1'b1, $sformatf("vec%0d", i));
        end

        do_reset();
        for (int k = 0; k < 3; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            d_first = (k == 1);
`else
            d_first = 1'b1;
`endif
            collide(32'h1000 + 32'(k * 64), 32'h4000 + 32'(k * 64), d_first, $sformatf("col%0d", k));
        end

        // Writeback then fill from D while I is pending.
`ifdef ARB_ROUND_ROBIN_EN
        sb_q.push_back('{addr: 32'h3000, wdata: {32{8'h77}}, write: 1'b1, rdata: {32{8'h01}}, lat: 4, stall: 0});
        sb_q.push_back('{addr: 32'h500,  wdata: '0, write: 1'b0, rdata: {32{8'h5A}}, lat: 2, stall: 0});
        sb_q.push_back('{addr: 32'h3040, wdata: '0, write: 1'b0, rdata: {32{8'hE7}}, lat: 2, stall: 0});
`else
        sb_q.push_back('{addr: 32'h3000, wdata: {32{8'h77}}, write: 1'b1, rdata: {32{8'h01}}, lat: 4, stall: 0});
        sb_q.push_back('{addr: 32'h3040, wdata: '0, write: 1'b0, rdata: {32{8'hE7}}, lat: 2, stall: 0});
        sb_q.push_back('{addr: 32'h500,  wdata: '0, write: 1'b0, rdata: {32{8'h5A}}, lat: 2, stall: 0});
`endif
        fork
            begin
                client_req(1, 32'h3000, {32{8'h77}}, 1'b1, {32{8'h01}}, 1'b0, 1'b1, "wb");
                client_req(1, 32'h3040, '0, 1'b0, {32{8'hE7}}, 1'b0, 1'b0, "fill");
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                client_req(0, 32'h500, '0, 1'b0, {32{8'h5A}}, 1'b0, 1'b0, "i_pend");
            end
        join

        // Reset during WAIT with memory handshake driven by hand.
        @(posedge clk); #1;
        mem_auto = 1'b0;
        set_req(0, 32'h300, '0, 1'b0);
        @(posedge clk); #1;
        check("rwait_issue_valid", LW'(mem_if.valid), LW'(1));
        mem_if.ready = 1'b0;
        @(posedge clk); #1;
        check("rwait_wait_valid", LW'(mem_if.valid), LW'(0));
        check("rwait_wait_addr", LW'(mem_if.addr), LW'(32'h300));
        #2;
        rst_n = 1'b0;
        mem_if.ready = 1'b1;
        #1;
        check("rwait_valid", LW'(mem_if.valid), LW'(0));
        check("rwait_addr", LW'(mem_if.addr), LW'(0));
        check("rwait_i_ready", LW'(icache_if.ready), LW'(1));
        check("rwait_rd_clear", icache_if.rd_data, '0);
        drop_valid(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_auto = 1'b1;
        sb_q.push_back('{addr: 32'h340, wdata: '0, write: 1'b0, rdata: {8{32'h600DF00D}}, lat: 2, stall: 0});
        client_req(0, 32'h340, '0, 1'b0, {8{32'h600DF00D}}, 1'b0, 1'b1, "post_rst");

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", LW'(sb_q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
